vrelu_stage: RTL and testbench

- Vector ReLU/requantise stage directly downstream of vwb_mac in the MLInference chain.
- Reads one vector in WorkingRegs-element chunks from the v_fifo that vwb_mac writes, computes max(0, x >>> Shift) per element, and writes chunks into the next v_fifo.
- Uses the same chunk-request handshake as vwb_mac, so stages chain fifo-to-fifo without glue.

---
 rtl/ml_pkg.sv | 31 +++
 rtl/vrelu_lane.sv | 25 ++
 rtl/vrelu_stage.sv | 121 ++++++++++++
 tb/tb_vrelu_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ml_pkg.sv
// Shared definitions for the MLInference vector stages.
// Holds the vrelu_stage state encoding, the chunk-count helper used by the
// chunked stages, and the scalar shift-then-ReLU used by each lane.
package ml_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE
  } vrelu_state_t;

  // Widest element the scalar helper handles; lanes sign-extend into this.
  localparam int unsigned ReluMaxBits = 64;

  // Number of chunks needed to cover a vector (ceiling division).
  function automatic int unsigned ceil_div(input int unsigned num,
                                           input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  // Arithmetic right shift followed by clamp of negatives to zero.
  function automatic logic signed [ReluMaxBits-1:0] relu_shift(
      input logic signed [ReluMaxBits-1:0] x, input int sh);
    logic signed [ReluMaxBits-1:0] y;
    y = x >>> sh;
    return (y < 0) ? '0 : y;
  endfunction

endpackage

// File: rtl/vrelu_lane.sv
// Single combinational ReLU/requantise lane.
// Ports:
//   in_i   : signed element from the input chunk
//   mask_i : 1 = lane carries a real element, 0 = padding lane (forced to 0)
//   out_o  : max(0, in_i >>> Shift), or 0 when masked
module vrelu_lane
  import ml_pkg::*;
#(
  parameter int unsigned NBits = 8,
  parameter int unsigned Shift = 0
) (
  input  logic [NBits-1:0] in_i,
  input  logic             mask_i,
  output logic [NBits-1:0] out_o
);

  logic signed [ReluMaxBits-1:0] x_ext;

  // Sign-extend so the shared helper sees the true signed value.
  assign x_ext = {{(ReluMaxBits - NBits){in_i[NBits-1]}}, in_i};

  // A non-negative shifted value never exceeds the input range, so truncation is exact.
  assign out_o = mask_i ? NBits'(relu_shift(x_ext, int'(Shift))) : '0;

endmodule

// File: rtl/vrelu_stage.sv
// Vector ReLU/requantise stage: reads a vector chunk by chunk from the
// upstream fifo, applies max(0, x >>> Shift) per element and writes each
// result chunk to the downstream fifo.
// Ports:
//   clk_in, rst_in    : clock, synchronous active-low reset
//   in_data_ready     : upstream holds a full vector (level or pulse)
//   in_data           : upstream chunk, valid one cycle after req_chunk_in
//   req_chunk_in      : one-cycle read strobe to upstream fifo
//   write_out_data    : result chunk to downstream fifo
//   req_chunk_out     : one-cycle write strobe to downstream fifo
//   out_vector_valid  : one-cycle pulse after the last chunk is written
//   busy              : high whenever the FSM is not idle
module vrelu_stage
  import ml_pkg::*;
#(
  parameter int unsigned InVecLength = 5,
  parameter int unsigned WorkingRegs = 5,
  parameter int unsigned NBits       = 8,
  parameter int unsigned Shift       = 0
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                in_data_ready,
  input  logic [WorkingRegs-1:0][NBits-1:0]   in_data,
  output logic                                req_chunk_in,
  output logic [WorkingRegs-1:0][NBits-1:0]   write_out_data,
  output logic                                req_chunk_out,
  output logic                                out_vector_valid,
  output logic                                busy
);

  localparam int unsigned NChunks = ceil_div(InVecLength, WorkingRegs);
  localparam int unsigned CntW    = $clog2(NChunks) + 1;
  localparam int unsigned Rem     = InVecLength % WorkingRegs;
  localparam logic [CntW-1:0] LastChunk = CntW'(NChunks - 1);

  vrelu_state_t                        state_q;
  logic [CntW-1:0]                     cnt_q;
  logic                                pending_q;
  logic                                last_chunk;
  logic [WorkingRegs-1:0]              lane_mask;
  logic [WorkingRegs-1:0][NBits-1:0]   lane_res;

  assign last_chunk = (cnt_q == LastChunk);

  // Lanes past the remainder in the final chunk are padding and forced to 0.
  for (genvar gi = 0; gi < int'(WorkingRegs); gi++) begin : g_lane
    assign lane_mask[gi] = (Rem == 0) || !last_chunk || (gi < int'(Rem));

    vrelu_lane #(
      .NBits(NBits),
      .Shift(Shift)
    ) u_lane (
      .in_i  (in_data[gi]),
      .mask_i(lane_mask[gi]),
      .out_o (lane_res[gi])
    );
  end

  // Chunk sequencer; strobes are set on the transition into their state.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      pending_q        <= 1'b0;
      req_chunk_in     <= 1'b0;
      req_chunk_out    <= 1'b0;
      out_vector_valid <= 1'b0;
      busy             <= 1'b0;
      write_out_data   <= '0;
    end else begin
      req_chunk_in     <= 1'b0;
      req_chunk_out    <= 1'b0;
      out_vector_valid <= 1'b0;

      // A request arriving while a vector is in flight is remembered once.
      if (in_data_ready && (state_q != IDLE)) begin
        pending_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (in_data_ready || pending_q) begin
            state_q      <= READ;
            pending_q    <= 1'b0;
            req_chunk_in <= 1'b1;
            busy         <= 1'b1;
          end
        end
        READ: begin
          state_q <= WAIT;
        end
        WAIT: begin
          write_out_data <= lane_res;
          req_chunk_out  <= 1'b1;
          state_q        <= WRITE;
        end
        WRITE: begin
          if (last_chunk) begin
            cnt_q            <= '0;
            out_vector_valid <= 1'b1;
            state_q          <= DONE;
          end else begin
            cnt_q        <= cnt_q + CntW'(1);
            req_chunk_in <= 1'b1;
            state_q      <= READ;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vrelu_stage.sv
// Bench for vrelu_stage: three instances (default, Shift=2, 12-element
// multi-chunk) driven by a bench-owned fifo model; expectations come from
// plain arithmetic on the element values and the stage's cycle timing.
module tb_vrelu_stage;

  typedef logic [4:0][7:0] chunk_t;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   in_rdy  [3];
  chunk_t in_dat  [3];
  logic   req_in  [3];
  logic   req_out [3];
  logic   ovv     [3];
  logic   busy    [3];
  chunk_t wdat    [3];

  chunk_t fifo_mem [3][16];
  int     wr_ptr   [3];
  int     rd_ptr   [3];
  logic   req_seen [3];
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    vrelu_stage #(
      .InVecLength((g == 2) ? 12 : 5),
      .WorkingRegs(5),
      .NBits(8),
      .Shift((g == 1) ? 2 : 0)
    ) u_dut (
      .clk_in          (clk),
      .rst_in          (rst_n),
      .in_data_ready   (in_rdy[g]),
      .in_data         (in_dat[g]),
      .req_chunk_in    (req_in[g]),
      .write_out_data  (wdat[g]),
      .req_chunk_out   (req_out[g]),
      .out_vector_valid(ovv[g]),
      .busy            (busy[g])
    );
  end

  function automatic int dlen(input int d);
    return (d == 2) ? 12 : 5;
  endfunction

  function automatic int dsh(input int d);
    return (d == 1) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: the fifo model answers last cycle's read strobe just after the edge,
  // otherwise it drives junk; outputs are then sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      if (req_seen[d]) begin
        in_dat[d] = fifo_mem[d][rd_ptr[d] % 16];
        rd_ptr[d]++;
      end else begin
        in_dat[d] = 40'({$urandom(), $urandom()});
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) req_seen[d] = req_in[d];
  endtask

  task automatic check_idle(input int d, input string tag);
    chk($sformatf("%s d%0d req_in", tag, d), 64'(req_in[d]), 64'(0));
    chk($sformatf("%s d%0d req_out", tag, d), 64'(req_out[d]), 64'(0));
    chk($sformatf("%s d%0d ovv", tag, d), 64'(ovv[d]), 64'(0));
    chk($sformatf("%s d%0d busy", tag, d), 64'(busy[d]), 64'(0));
  endtask

  // rdy_mode: 0 = rely on pending, 1 = one-cycle pulse, 2 = leave high.
  // abort_at: cycle after which reset is applied (0 = never).
  task automatic run_vec(input int d, input int vals[12], input int rdy_mode,
                         input bit done_pulse, input int abort_at);
    int     len;
    int     sh;
    int     nch;
    int     idx;
    int     ci;
    chunk_t in_c;
    chunk_t exp_c [3];
    len = dlen(d);
    sh  = dsh(d);
    nch = (len + 4) / 5;
    for (int c = 0; c < nch; c++) begin
      for (int i = 0; i < 5; i++) begin
        idx = c * 5 + i;
        if (idx < len) begin
          in_c[i]     = 8'(vals[idx]);
          exp_c[c][i] = (vals[idx] < 0) ? 8'd0 : 8'(vals[idx] / (1 << sh));
        end else begin
          in_c[i]     = 8'($urandom());
          exp_c[c][i] = 8'd0;
        end
      end
      fifo_mem[d][wr_ptr[d] % 16] = in_c;
      wr_ptr[d]++;
    end
    if (rdy_mode != 0) in_rdy[d] = 1'b1;
    for (int t = 1; t <= 3 * nch + 2; t++) begin
      tick();
      if (t == 1 && rdy_mode == 1) in_rdy[d] = 1'b0;
      chk($sformatf("d%0d t%0d req_in", d, t), 64'(req_in[d]),
          64'(t <= 3 * nch && t % 3 == 1));
      chk($sformatf("d%0d t%0d req_out", d, t), 64'(req_out[d]),
          64'(t <= 3 * nch && t % 3 == 0));
      chk($sformatf("d%0d t%0d ovv", d, t), 64'(ovv[d]), 64'(t == 3 * nch + 1));
      chk($sformatf("d%0d t%0d busy", d, t), 64'(busy[d]), 64'(t <= 3 * nch + 1));
      if (t >= 3) begin
        ci = t / 3 - 1;
        if (ci > nch - 1) ci = nch - 1;
        chk($sformatf("d%0d t%0d wdata", d, t), 64'(wdat[d]), 64'(exp_c[ci]));
      end
      if (t == abort_at) begin
        rst_n = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
          check_idle(k, "abort");
          chk($sformatf("abort d%0d wdata", k), 64'(wdat[k]), 64'(0));
        end
        rst_n     = 1'b1;
        in_rdy[d] = 1'b0;
        rd_ptr[d] = wr_ptr[d];
        return;
      end
      if (done_pulse && t == 3 * nch + 1) in_rdy[d] = 1'b1;
      if (done_pulse && t == 3 * nch + 2) in_rdy[d] = 1'b0;
    end
  endtask

  task automatic rand_vals(output int vals[12]);
    logic [7:0] b;
    for (int i = 0; i < 12; i++) begin
      b       = 8'($urandom());
      vals[i] = int'($signed(b));
    end
  endtask

  initial begin
    int vals[12];
    int gap;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_rdy[d]   = 1'b0;
      in_dat[d]   = '0;
      req_seen[d] = 1'b0;
      wr_ptr[d]   = 0;
      rd_ptr[d]   = 0;
    end
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      check_idle(d, "reset");
      chk($sformatf("reset d%0d wdata", d), 64'(wdat[d]), 64'(0));
    end
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) check_idle(d, "post_reset");

    // Basic vector, then shifted vector, then multi-chunk with padding lanes.
    vals = '{-3, 0, 7, 127, -128, 0, 0, 0, 0, 0, 0, 0};
    run_vec(0, vals, 1, 1'b0, 0);
    vals = '{-9, 13, -1, 4, 127, 0, 0, 0, 0, 0, 0, 0};
    run_vec(1, vals, 1, 1'b0, 0);
    vals = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
    run_vec(2, vals, 1, 1'b0, 0);

    // Random vectors with random idle gaps.
    for (int r = 0; r < 4; r++) begin
      for (int d = 0; d < 3; d++) begin
        rand_vals(vals);
        run_vec(d, vals, 1, 1'b0, 0);
        gap = int'($urandom_range(0, 3));
        for (int k = 0; k < gap; k++) begin
          tick();
          check_idle(d, "gap");
        end
      end
    end

    // Ready held high through a vector: exactly one follow-on vector.
    rand_vals(vals);
    run_vec(0, vals, 2, 1'b0, 0);
    rand_vals(vals);
    run_vec(0, vals, 1, 1'b0, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_idle(0, "b2b_tail");
    end

    // Reset during the second chunk's WAIT, then a clean restart.
    rand_vals(vals);
    run_vec(2, vals, 1, 1'b0, 5);
    for (int k = 0; k < 2; k++) begin
      tick();
      check_idle(2, "post_abort");
    end
    rand_vals(vals);
    run_vec(2, vals, 1, 1'b0, 0);

    // Ready pulsed only in the DONE cycle starts exactly one more vector.
    for (int d = 0; d < 3; d += 2) begin
      rand_vals(vals);
      run_vec(d, vals, 1, 1'b1, 0);
      rand_vals(vals);
      run_vec(d, vals, 0, 1'b0, 0);
      for (int k = 0; k < 4; k++) begin
        tick();
        check_idle(d, "collide_tail");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
